// File: rtl/radix3_fft_seq.sv
// Sequencer for an in-place radix-3 DIF FFT built around one shared radix-3 butterfly.
// Issues triplet read addresses and twiddle exponents, and delays them to form write-back.
module radix3_fft_seq #(
   parameter int unsigned STAGES = 2,
   parameter int unsigned BF_LAT = 3,
   parameter int unsigned ADDR_W = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   output logic                           busy,
   output logic                           done,
   output logic                           rd_en,
   output logic [ADDR_W-1:0]              rd_addr0,
   output logic [ADDR_W-1:0]              rd_addr1,
   output logic [ADDR_W-1:0]              rd_addr2,
   output logic                           bf_in_valid,
   output logic [ADDR_W-1:0]              tw_exp,
   output logic [$clog2(STAGES+1)-1:0]    stage,
   output logic                           wr_en,
   output logic [ADDR_W-1:0]              wr_addr0,
   output logic [ADDR_W-1:0]              wr_addr1,
   output logic [ADDR_W-1:0]              wr_addr2
);

   function automatic int unsigned pow3(input int unsigned e);
      int unsigned r;
      r = 1;
      for (int unsigned i = 0; i < e; i++) r = r * 3;
      return r;
   endfunction

   // Multiplicative inverse of 3 modulo 2^32 (Newton iteration); exact division of multiples of 3.
   function automatic int unsigned inv3_calc();
      int unsigned x;
      x = 3;
      for (int i = 0; i < 5; i++) x = x * (32'd2 - 32'd3 * x);
      return x;
   endfunction

   localparam int unsigned N     = pow3(STAGES);
   localparam int unsigned NB    = N / 3;
   localparam int unsigned DEPTH = 1 + BF_LAT;
   localparam int unsigned SW    = $clog2(STAGES + 1);
   localparam int unsigned CW    = $clog2(DEPTH + 1);

   localparam logic [ADDR_W-1:0] SPAN0   = ADDR_W'(pow3(STAGES - 1));
   localparam logic [ADDR_W-1:0] INV3    = ADDR_W'(inv3_calc());
   localparam logic [ADDR_W-1:0] LAST_BF = ADDR_W'(NB - 1);
   localparam logic [CW-1:0]     LAST_DR = CW'(DEPTH - 1);
   localparam logic [SW-1:0]     LAST_ST = SW'(STAGES - 1);

   typedef enum logic [1:0] {StIdle, StIssue, StDrain, StFin} state_t;

   state_t              state_q, state_d;
   logic [SW-1:0]       stage_q, stage_d;
   logic [ADDR_W-1:0]   j_q, j_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [ADDR_W-1:0]   span_q, span_d;
   logic [ADDR_W-1:0]   p3_q, p3_d;
   logic [ADDR_W-1:0]   tw_q, tw_d;
   logic [ADDR_W-1:0]   bf_cnt_q, bf_cnt_d;
   logic [CW-1:0]       drain_q, drain_d;

   logic [ADDR_W-1:0]   a0, a1, a2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         stage_q  <= '0;
         j_q      <= '0;
         base_q   <= '0;
         span_q   <= '0;
         p3_q     <= '0;
         tw_q     <= '0;
         bf_cnt_q <= '0;
         drain_q  <= '0;
      end else begin
         state_q  <= state_d;
         stage_q  <= stage_d;
         j_q      <= j_d;
         base_q   <= base_d;
         span_q   <= span_d;
         p3_q     <= p3_d;
         tw_q     <= tw_d;
         bf_cnt_q <= bf_cnt_d;
         drain_q  <= drain_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      stage_d  = stage_q;
      j_d      = j_q;
      base_d   = base_q;
      span_d   = span_q;
      p3_d     = p3_q;
      tw_d     = tw_q;
      bf_cnt_d = bf_cnt_q;
      drain_d  = drain_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d  = StIssue;
               stage_d  = '0;
               j_d      = '0;
               base_d   = '0;
               span_d   = SPAN0;
               p3_d     = ADDR_W'(1);
               tw_d     = '0;
               bf_cnt_d = '0;
            end
         end
         StIssue: begin
            bf_cnt_d = bf_cnt_q + 1'b1;
            if (j_q == span_q - 1'b1) begin
               j_d    = '0;
               tw_d   = '0;
               base_d = base_q + (span_q << 1) + span_q;
            end else begin
               j_d  = j_q + 1'b1;
               tw_d = tw_q + p3_q;
            end
            if (bf_cnt_q == LAST_BF) begin
               state_d = StDrain;
               drain_d = '0;
            end
         end
         StDrain: begin
            drain_d = drain_q + 1'b1;
            if (drain_q == LAST_DR) begin
               j_d      = '0;
               base_d   = '0;
               tw_d     = '0;
               bf_cnt_d = '0;
               if (stage_q == LAST_ST) begin
                  state_d = StFin;
               end else begin
                  state_d = StIssue;
                  stage_d = stage_q + 1'b1;
                  span_d  = span_q * INV3;
                  p3_d    = (p3_q << 1) + p3_q;
               end
            end
         end
         StFin: begin
            state_d = StIdle;
            stage_d = '0;
         end
         default: state_d = StIdle;
      endcase
   end

   assign busy  = (state_q != StIdle);
   assign done  = (state_q == StFin);
   assign rd_en = (state_q == StIssue);
   assign stage = stage_q;

   assign a0 = base_q + j_q;
   assign a1 = a0 + span_q;
   assign a2 = a1 + span_q;

   // Gated so idle/drain cycles present all-zero addresses.
   assign rd_addr0 = rd_en ? a0 : '0;
   assign rd_addr1 = rd_en ? a1 : '0;
   assign rd_addr2 = rd_en ? a2 : '0;

   logic                bv_q;
   logic [ADDR_W-1:0]   tw_exp_q;
   logic [DEPTH-1:0]    we_pipe_q;
   logic [ADDR_W-1:0]   wa0_pipe_q [DEPTH];
   logic [ADDR_W-1:0]   wa1_pipe_q [DEPTH];
   logic [ADDR_W-1:0]   wa2_pipe_q [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bv_q      <= 1'b0;
         tw_exp_q  <= '0;
         we_pipe_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            wa0_pipe_q[i] <= '0;
            wa1_pipe_q[i] <= '0;
            wa2_pipe_q[i] <= '0;
         end
      end else begin
         bv_q          <= rd_en;
         tw_exp_q      <= rd_en ? tw_q : '0;
         we_pipe_q[0]  <= rd_en;
         wa0_pipe_q[0] <= rd_addr0;
         wa1_pipe_q[0] <= rd_addr1;
         wa2_pipe_q[0] <= rd_addr2;
         for (int i = 1; i < DEPTH; i++) begin
            we_pipe_q[i]  <= we_pipe_q[i-1];
            wa0_pipe_q[i] <= wa0_pipe_q[i-1];
            wa1_pipe_q[i] <= wa1_pipe_q[i-1];
            wa2_pipe_q[i] <= wa2_pipe_q[i-1];
         end
      end
   end

   assign bf_in_valid = bv_q;
   assign tw_exp      = tw_exp_q;
   assign wr_en       = we_pipe_q[DEPTH-1];
   assign wr_addr0    = wa0_pipe_q[DEPTH-1];
   assign wr_addr1    = wa1_pipe_q[DEPTH-1];
   assign wr_addr2    = wa2_pipe_q[DEPTH-1];

endmodule

// File: tb/tb_radix3_fft_seq.sv
// Directed bench for radix3_fft_seq: 9-point default instance plus a 27-point, BF_LAT=1 instance.
module tb_radix3_fft_seq;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0;
   logic start2 = 1'b0;

   logic       busy, done, rd_en, bf_in_valid, wr_en;
   logic [3:0] rd_addr0, rd_addr1, rd_addr2, tw_exp, wr_addr0, wr_addr1, wr_addr2;
   logic [1:0] stage;

   logic       busy2, done2, rd_en2, bf_in_valid2, wr_en2;
   logic [4:0] rd2_a0, rd2_a1, rd2_a2, tw_exp2, wr2_a0, wr2_a1, wr2_a2;
   logic [1:0] stage2;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   radix3_fft_seq #(.STAGES(2), .BF_LAT(3), .ADDR_W(4)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .rd_en(rd_en),
      .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .bf_in_valid(bf_in_valid), .tw_exp(tw_exp), .stage(stage), .wr_en(wr_en),
      .wr_addr0(wr_addr0), .wr_addr1(wr_addr1), .wr_addr2(wr_addr2)
   );

   radix3_fft_seq #(.STAGES(3), .BF_LAT(1), .ADDR_W(5)) dut27 (
      .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2), .rd_en(rd_en2),
      .rd_addr0(rd2_a0), .rd_addr1(rd2_a1), .rd_addr2(rd2_a2),
      .bf_in_valid(bf_in_valid2), .tw_exp(tw_exp2), .stage(stage2), .wr_en(wr_en2),
      .wr_addr0(wr2_a0), .wr_addr1(wr2_a1), .wr_addr2(wr2_a2)
   );

   // Triplets of a 9-point frame in issue order: stage 0 then stage 1.
   int trip [6][3] = '{'{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8}, '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8}};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Caller is at cycle 0 of the frame; returns at cycle 16 (idle again).
   // mode 0: single start pulse; 1: start held through cycle 15; 2: extra pulse at cycle 6.
   task automatic run_frame(input int mode, input string name);
      int wr_cnt;
      int done_cnt;
      int e_rd, e_bv, e_wr, t;
      wr_cnt   = 0;
      done_cnt = 0;
      start    = 1'b1;
      chk({name, " busy@0"}, 32'(busy), 0);
      for (int c = 1; c <= 16; c++) begin
         tick();
         start = ((mode == 1) && (c <= 15)) || ((mode == 2) && (c == 6));
         e_rd = ((c >= 1) && (c <= 3)) || ((c >= 8) && (c <= 10));
         e_bv = ((c >= 2) && (c <= 4)) || ((c >= 9) && (c <= 11));
         e_wr = ((c >= 5) && (c <= 7)) || ((c >= 12) && (c <= 14));
         chk($sformatf("%s rd_en@%0d", name, c), 32'(rd_en), 32'(e_rd));
         chk($sformatf("%s bf_in_valid@%0d", name, c), 32'(bf_in_valid), 32'(e_bv));
         chk($sformatf("%s wr_en@%0d", name, c), 32'(wr_en), 32'(e_wr));
         chk($sformatf("%s busy@%0d", name, c), 32'(busy), 32'(c <= 15));
         chk($sformatf("%s done@%0d", name, c), 32'(done), 32'(c == 15));
         if (e_rd != 0) begin
            t = (c <= 3) ? c - 1 : c - 5;
            chk($sformatf("%s rd_addr0@%0d", name, c), 32'(rd_addr0), 32'(trip[t][0]));
            chk($sformatf("%s rd_addr1@%0d", name, c), 32'(rd_addr1), 32'(trip[t][1]));
            chk($sformatf("%s rd_addr2@%0d", name, c), 32'(rd_addr2), 32'(trip[t][2]));
            chk($sformatf("%s stage@%0d", name, c), 32'(stage), 32'(c >= 8));
         end
         if (e_bv != 0)
            chk($sformatf("%s tw_exp@%0d", name, c), 32'(tw_exp), 32'((c <= 4) ? c - 2 : 0));
         if (e_wr != 0) begin
            t = (c <= 7) ? c - 5 : c - 9;
            chk($sformatf("%s wr_addr0@%0d", name, c), 32'(wr_addr0), 32'(trip[t][0]));
            chk($sformatf("%s wr_addr1@%0d", name, c), 32'(wr_addr1), 32'(trip[t][1]));
            chk($sformatf("%s wr_addr2@%0d", name, c), 32'(wr_addr2), 32'(trip[t][2]));
         end
         wr_cnt   += int'(wr_en);
         done_cnt += int'(done);
      end
      chk({name, " wr_en count"}, 32'(wr_cnt), 6);
      chk({name, " done count"}, 32'(done_cnt), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int wr2_cnt;
      int done2_cnt;

      #1 rst = 1'b1;
      tick();
      tick();
      chk("reset busy", 32'(busy), 0);
      chk("reset rd_en", 32'(rd_en), 0);
      chk("reset wr_en", 32'(wr_en), 0);
      chk("reset rd_addr1", 32'(rd_addr1), 0);
      chk("reset done", 32'(done), 0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      run_frame(0, "f1");
      run_frame(2, "f2_b2b_pulse6");
      run_frame(1, "f3_held");
      tick();
      tick();
      chk("idle after held busy", 32'(busy), 0);
      chk("idle after held wr_en", 32'(wr_en), 0);

      // Asynchronous reset in the middle of the first drain, with writes still pending.
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      chk("pre-rst wr_en@6", 32'(wr_en), 1);
      chk("pre-rst wr_addr0@6", 32'(wr_addr0), 1);
      #2 rst = 1'b1;
      #1;
      chk("async rst wr_en", 32'(wr_en), 0);
      chk("async rst wr_addr0", 32'(wr_addr0), 0);
      chk("async rst wr_addr2", 32'(wr_addr2), 0);
      chk("async rst busy", 32'(busy), 0);
      chk("async rst bf_in_valid", 32'(bf_in_valid), 0);
      chk("async rst tw_exp", 32'(tw_exp), 0);
      chk("async rst stage", 32'(stage), 0);
      tick();
      @(negedge clk);
      rst = 1'b0;
      tick();
      for (int c = 0; c < 8; c++) begin
         chk($sformatf("post-rst wr_en+%0d", c), 32'(wr_en), 0);
         chk($sformatf("post-rst busy+%0d", c), 32'(busy), 0);
         tick();
      end
      run_frame(0, "f4_after_rst");

      // 27-point instance, BF_LAT = 1.
      wr2_cnt   = 0;
      done2_cnt = 0;
      start2    = 1'b1;
      for (int c = 1; c <= 35; c++) begin
         tick();
         start2 = 1'b0;
         if (c == 2)  chk("n27 wr_en@2", 32'(wr_en2), 0);
         if (c == 3)  chk("n27 wr_en@3", 32'(wr_en2), 1);
         if (c == 21) chk("n27 rd_en@21", 32'(rd_en2), 0);
         if (c == 22) chk("n27 rd_en@22", 32'(rd_en2), 0);
         if ((c >= 12) && (c <= 14)) begin
            chk($sformatf("n27 rd_addr0@%0d", c), 32'(rd2_a0), 32'(c - 12));
            chk($sformatf("n27 rd_addr1@%0d", c), 32'(rd2_a1), 32'(c - 9));
            chk($sformatf("n27 rd_addr2@%0d", c), 32'(rd2_a2), 32'(c - 6));
            chk($sformatf("n27 stage@%0d", c), 32'(stage2), 1);
         end
         if ((c >= 13) && (c <= 15))
            chk($sformatf("n27 tw_exp@%0d", c), 32'(tw_exp2), 32'(3 * (c - 13)));
         if (c == 23) begin
            chk("n27 rd_addr0@23", 32'(rd2_a0), 0);
            chk("n27 rd_addr1@23", 32'(rd2_a1), 1);
            chk("n27 rd_addr2@23", 32'(rd2_a2), 2);
            chk("n27 stage@23", 32'(stage2), 2);
         end
         if (c == 34) chk("n27 done@34", 32'(done2), 1);
         if (c == 35) chk("n27 busy@35", 32'(busy2), 0);
         wr2_cnt   += int'(wr_en2);
         done2_cnt += int'(done2);
      end
      chk("n27 wr_en count", 32'(wr2_cnt), 27);
      chk("n27 done count", 32'(done2_cnt), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
